// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - byte-stream command parser driving single-word PicoRV32 native bus transactions
module uart_bus_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam logic [7:0]  CMD_READ  = 8'h52;
    localparam logic [7:0]  CMD_WRITE = 8'h57;
    localparam logic [7:0]  RSP_OK    = 8'h4B;
    localparam logic [7:0]  RSP_TMO   = 8'h54;
    localparam logic [7:0]  RSP_BAD   = 8'h3F;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_sr_q, addr_sr_d;
    logic [31:0] data_sr_q, data_sr_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [15:0] timer_q, timer_d;
    logic [23:0] resp_sr_q, resp_sr_d;
    logic [1:0]  rem_q, rem_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        rx_fire, tx_fire;

    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        cnt_d       = cnt_q;
        addr_sr_d   = addr_sr_q;
        data_sr_d   = data_sr_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        timer_d     = timer_q;
        resp_sr_d   = resp_sr_q;
        rem_d       = rem_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;

        rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
        rx_fire  = rx_valid && rx_ready;
        tx_fire  = tx_valid_q && tx_ready;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                        is_write_d = (rx_data == CMD_WRITE);
                        cnt_d      = 2'd0;
                        state_d    = S_ADDR;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = RSP_BAD;
                        rem_d      = 2'd0;
                        state_d    = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    addr_sr_d = {rx_data, addr_sr_q[31:8]};
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (is_write_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d     = S_BUS;
                            mem_valid_d = 1'b1;
                            mem_addr_d  = {addr_sr_d[31:2], 2'b00};
                            mem_wdata_d = data_sr_q;
                            mem_wstrb_d = 4'h0;
                            timer_d     = 16'd0;
                        end
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    data_sr_d = {rx_data, data_sr_q[31:8]};
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d     = S_BUS;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {addr_sr_q[31:2], 2'b00};
                        mem_wdata_d = data_sr_d;
                        mem_wstrb_d = 4'hF;
                        timer_d     = 16'd0;
                    end
                end
            end
            S_BUS: begin
                // A ready arriving on the final timeout cycle still completes normally.
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    tx_valid_d  = 1'b1;
                    timer_d     = 16'd0;
                    state_d     = S_RESP;
                    if (is_write_q) begin
                        tx_data_d = RSP_OK;
                        rem_d     = 2'd0;
                    end else begin
                        tx_data_d = mem_rdata[7:0];
                        resp_sr_d = mem_rdata[31:8];
                        rem_d     = 2'd3;
                    end
                end else if (timer_q == TMO_LAST) begin
                    mem_valid_d = 1'b0;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = RSP_TMO;
                    rem_d       = 2'd0;
                    timer_d     = 16'd0;
                    state_d     = S_RESP;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            S_RESP: begin
                if (tx_fire) begin
                    if (rem_q == 2'd0) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d = resp_sr_q[7:0];
                        resp_sr_d = {8'h00, resp_sr_q[23:8]};
                        rem_d     = rem_q - 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            is_write_q  <= 1'b0;
            cnt_q       <= 2'd0;
            addr_sr_q   <= 32'd0;
            data_sr_q   <= 32'd0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'h0;
            timer_q     <= 16'd0;
            resp_sr_q   <= 24'd0;
            rem_q       <= 2'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            cnt_q       <= cnt_d;
            addr_sr_q   <= addr_sr_d;
            data_sr_q   <= data_sr_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            timer_q     <= timer_d;
            resp_sr_q   <= resp_sr_d;
            rem_q       <= rem_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_instr = 1'b0;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - frame-level model and directed vectors for uart_bus_master
module tb_uart_bus_master;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'd0;
    logic        busy;

    uart_bus_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Responder and sink configuration
    int          lat = 0;
    bit          ack_en = 1'b1;
    logic [31:0] rd_cfg = 32'd0;
    bit          tog = 1'b0;
    bit          txr_fixed = 1'b1;
    int          vcnt_r = 0;

    always @(posedge clk) begin
        #1;
        if (tog) tx_ready = ~tx_ready;
        else     tx_ready = txr_fixed;
        if (mem_valid) begin
            mem_ready = ack_en && (vcnt_r == lat);
            vcnt_r++;
        end else begin
            mem_ready = 1'b0;
            vcnt_r = 0;
        end
        mem_rdata = mem_ready ? rd_cfg : 32'h0BADF00D;
    end

    // Frame-level model state
    logic [7:0]  exp_q[$];
    logic [7:0]  log_q[$];
    logic [7:0]  fb [0:8];
    int          fcnt = 0;
    bit          fwrite = 1'b0;
    bit          bus_ph = 1'b0;
    bit          exp_wr = 1'b0;
    logic [31:0] e_addr = 32'd0;
    logic [31:0] e_wdata = 32'd0;
    logic [3:0]  e_wstrb = 4'd0;
    int          vcount = 0;
    int          txn_cnt = 0;
    int          l_vcnt = 0;
    logic [31:0] l_addr = 32'd0;
    logic [31:0] l_wdata = 32'd0;
    logic [3:0]  l_wstrb = 4'd0;
    bit          prev_valid = 1'b0;
    bit          stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'd0;

    function void model_rx(input logic [7:0] b);
        if (fcnt == 0) begin
            if (b == 8'h52 || b == 8'h57) begin
                fwrite = (b == 8'h57);
                fb[0] = b;
                fcnt = 1;
            end else begin
                exp_q.push_back(8'h3F);
            end
        end else begin
            fb[fcnt] = b;
            fcnt++;
            if (fcnt == (fwrite ? 9 : 5)) begin
                e_addr  = {fb[4], fb[3], fb[2], fb[1]} & 32'hFFFF_FFFC;
                e_wdata = {fb[8], fb[7], fb[6], fb[5]};
                e_wstrb = fwrite ? 4'hF : 4'h0;
                exp_wr  = fwrite;
                bus_ph  = 1'b1;
                vcount  = 0;
                fcnt    = 0;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_mem_valid", 32'(mem_valid), 32'd0);
            chk("rst_tx_valid", 32'(tx_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rx_ready", 32'(rx_ready), 32'd1);
            exp_q.delete();
            fcnt = 0;
            bus_ph = 1'b0;
            vcount = 0;
            prev_valid = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
            chk("rx_ready", 32'(rx_ready), 32'(!(bus_ph || exp_q.size() != 0)));
            chk("busy", 32'(busy), 32'(fcnt != 0 || bus_ph || exp_q.size() != 0));
            chk("mem_valid", 32'(mem_valid), 32'(bus_ph));
            chk("mem_instr", 32'(mem_instr), 32'd0);
            if (stall_prev && tx_valid) chk("tx_stable", 32'(tx_data), 32'(stall_data));
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (mem_valid) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
                if (exp_wr) chk("mem_wdata", mem_wdata, e_wdata);
                if (!prev_valid) begin
                    txn_cnt++;
                    l_vcnt = 0;
                end
                l_vcnt++;
                l_addr  = mem_addr;
                l_wdata = mem_wdata;
                l_wstrb = mem_wstrb;
            end
            prev_valid = mem_valid;
            if (bus_ph && mem_valid) begin
                vcount++;
                if (mem_ready) begin
                    bus_ph = 1'b0;
                    if (exp_wr) exp_q.push_back(8'h4B);
                    else for (int i = 0; i < 4; i++) exp_q.push_back(rd_cfg[8*i +: 8]);
                end else if (vcount == TO) begin
                    bus_ph = 1'b0;
                    exp_q.push_back(8'h54);
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) chk("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                else chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
                log_q.push_back(tx_data);
            end
            if (rx_valid && rx_ready) model_rx(rx_data);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        do begin
            @(negedge clk);
            k++;
        end while (!rx_ready && k < 200);
        if (!rx_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_accept_timeout: got rx_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_rd(input logic [31:0] a);
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    endtask

    task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || bus_ph || fcnt != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy after 300 cycles expected idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int t0;
        int k;
        // Reset with a byte offered that must be ignored
        rx_valid = 1'b1;
        rx_data  = 8'h57;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rx_valid = 1'b0;
        resetn   = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Write LED register
        lat = 0;
        log_q.delete();
        t0 = txn_cnt;
        send_wr(32'h0200_0000, 32'h0000_00A5);
        wait_idle();
        chk("wr_addr", l_addr, 32'h0200_0000);
        chk("wr_wdata", l_wdata, 32'h0000_00A5);
        chk("wr_wstrb", 32'(l_wstrb), 32'hF);
        chk("wr_valid_cycles", 32'(l_vcnt), 32'd1);
        chk("wr_txns", 32'(txn_cnt - t0), 32'd1);
        chk("wr_resp_len", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) chk("wr_resp", 32'(log_q[0]), 32'h4B);

        // Read RAM, 3-cycle responder
        lat = 3;
        rd_cfg = 32'hDEAD_BEEF;
        log_q.delete();
        send_rd(32'h0000_1004);
        wait_idle();
        chk("rd_addr", l_addr, 32'h0000_1004);
        chk("rd_wstrb", 32'(l_wstrb), 32'h0);
        chk("rd_valid_cycles", 32'(l_vcnt), 32'd4);
        chk("rd_resp_len", 32'(log_q.size()), 32'd4);
        if (log_q.size() >= 4) chk("rd_bytes", {log_q[0], log_q[1], log_q[2], log_q[3]}, 32'hEFBE_ADDE);

        // Misaligned address
        lat = 1;
        rd_cfg = 32'h0102_0304;
        log_q.delete();
        send_rd(32'h0000_1007);
        wait_idle();
        chk("mis_addr", l_addr, 32'h0000_1004);
        if (log_q.size() >= 4) chk("mis_bytes", {log_q[0], log_q[1], log_q[2], log_q[3]}, 32'h0403_0201);
        else chk("mis_resp_len", 32'(log_q.size()), 32'd4);

        // Unknown command
        log_q.delete();
        t0 = txn_cnt;
        send_byte(8'h41);
        wait_idle();
        chk("bad_txns", 32'(txn_cnt - t0), 32'd0);
        chk("bad_resp_len", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) chk("bad_resp", 32'(log_q[0]), 32'h3F);

        // Timeout, then a normal frame
        ack_en = 1'b0;
        log_q.delete();
        send_rd(32'h0900_0000);
        wait_idle();
        chk("tmo_addr", l_addr, 32'h0900_0000);
        chk("tmo_valid_cycles", 32'(l_vcnt), 32'd8);
        chk("tmo_resp_len", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) chk("tmo_resp", 32'(log_q[0]), 32'h54);
        ack_en = 1'b1;
        lat = 2;
        rd_cfg = 32'hCAFE_F00D;
        log_q.delete();
        send_rd(32'h0000_0010);
        wait_idle();
        chk("post_tmo_len", 32'(log_q.size()), 32'd4);
        if (log_q.size() >= 4) chk("post_tmo_bytes", {log_q[0], log_q[1], log_q[2], log_q[3]}, 32'h0DF0_FECA);

        // Backpressure with the next frame waiting on rx
        tog = 1'b1;
        lat = 2;
        rd_cfg = 32'h1122_3344;
        log_q.delete();
        send_rd(32'h0000_2000);
        send_wr(32'h0000_0010, 32'h1234_5678);
        wait_idle();
        tog = 1'b0;
        txr_fixed = 1'b1;
        chk("bp_resp_len", 32'(log_q.size()), 32'd5);
        if (log_q.size() >= 5) begin
            chk("bp_rd_bytes", {log_q[0], log_q[1], log_q[2], log_q[3]}, 32'h4433_2211);
            chk("bp_wr_resp", 32'(log_q[4]), 32'h4B);
        end
        chk("bp_wr_wdata", l_wdata, 32'h1234_5678);

        // Reset during the second write data byte
        @(posedge clk);
        #1;
        send_byte(8'h57);
        for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'hA0 : 8'h00);
        send_byte(8'h11);
        rx_valid = 1'b1;
        rx_data  = 8'h22;
        resetn   = 1'b0;
        #1;
        check_reset_outputs("rst_data");
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Reset while the bus request is outstanding
        ack_en = 1'b0;
        send_rd(32'h0000_3000);
        k = 0;
        while (!mem_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_bus_seen_valid", 32'(mem_valid), 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("rst_bus");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        ack_en = 1'b1;
        lat = 0;
        log_q.delete();
        send_wr(32'h0200_0000, 32'h0000_005A);
        wait_idle();
        chk("rst_after_len", 32'(log_q.size()), 32'd1);
        if (log_q.size() >= 1) chk("rst_after_resp", 32'(log_q[0]), 32'h4B);
        chk("rst_after_wdata", l_wdata, 32'h0000_005A);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

Debug bus initiator that turns a byte stream of commands into single-word transactions on the PicoRV32 native memory bus, then returns results as a byte stream. It sits between the `simpleuart`-style byte receive/transmit path and the SoC address decoder, beside the CPU port. With it, a host PC can peek and poke ROM, RAM and every memory-mapped peripheral (LEDs, segments, RGB, UART divisor, button register) without firmware involvement. Bus arbitration against the CPU is outside this block.

## Interface
Parameters:
- `TIMEOUT`, default 1024: bus cycles allowed for `mem_ready` before abort. Valid range is 2..65535.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  command byte present.
- `rx_data`  in  8  command byte.
- `rx_ready`  out  1  block accepts the byte this cycle.
- `tx_valid`  out  1  response byte present.
- `tx_data`  out  8  response byte.
- `tx_ready`  in  1  sink accepts the byte this cycle.
- `mem_valid`  out  1  bus request.
- `mem_instr`  out  1  constant 0.
- `mem_ready`  in  1  responder completion.
- `mem_addr`  out  32  word address, bits [1:0] forced to 0.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  4'hF for a write, 4'h0 for a read.
- `mem_rdata`  in  32  read data, valid when `mem_ready`=1.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation
- Frame format:
  - Read frame: `'R'`(0x52), then A0..A3.
  - Write frame: `'W'`(0x57), then A0..A3, then D0..D3.
  - Address and data bytes are little-endian (A0 is bits [7:0]).
- Responses:
  - Read: 4 bytes of rdata, little-endian.
  - Write: one byte `'K'`(0x4B).
  - Timeout: one byte `'T'`(0x54). A read that times out sends `'T'` and no data bytes.
  - Unknown command byte: one byte `'?'`(0x3F). No bus cycle is issued.
- States:
  - IDLE: `rx_ready`=1. On an accepted `'R'` or `'W'`, latch the command and go to ADDR. On any other byte, go to RESP carrying `'?'`.
  - ADDR: `rx_ready`=1. Shift in 4 bytes. After the 4th, a read goes to BUS and a write goes to DATA.
  - DATA: `rx_ready`=1. Shift in 4 bytes, then go to BUS.
  - BUS: `mem_valid`=1 and the timeout counter runs.
    - If `mem_ready`=1, capture `mem_rdata` and go to RESP.
    - If the counter reaches `TIMEOUT`-1 and `mem_ready`=0, go to RESP carrying `'T'`.
  - RESP: present the response bytes in order. After the last accepted byte, go to IDLE.
- `rx_ready`=0 in BUS and RESP. The upstream source holds the byte; no bytes are dropped.
- `mem_addr`, `mem_wdata` and `mem_wstrb` are loaded from the shift registers on entry to BUS. They stay stable for the whole time `mem_valid`=1.
- `mem_ready` is ignored while `mem_valid`=0.

## Timing
- Reset values: `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `mem_instr`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, state IDLE, counter 0.
  - `rx_ready` follows the state, so it reads 1 in IDLE.
  - Bytes offered while `resetn`=0 are ignored.
- A byte transfers on a cycle with `rx_valid`&&`rx_ready`.
- `mem_valid` rises on the cycle after the final frame byte is accepted. It is registered.
- `mem_valid` falls on the cycle after `mem_ready` is sampled high. The PicoRV32 single-cycle ready pulse therefore completes exactly one transaction.
- Timeout boundary:
  - `mem_valid` is high for at most `TIMEOUT` cycles.
  - If `mem_ready` and the timeout expire in the same cycle, `mem_ready` wins and the normal response is sent.
- Response handshake:
  - `tx_valid` rises on the cycle after BUS exits. For `'?'`, it rises on the cycle after the bad byte is accepted.
  - `tx_data` is stable while `tx_valid`&&!`tx_ready`.
  - The byte index advances only on `tx_valid`&&`tx_ready`.
  - `tx_valid` falls on the cycle after the last byte is accepted.
- Back-to-back frames: with `tx_ready` held 1, a read takes 5 rx cycles, then 1+L bus cycles (L = responder latency), then 4 tx cycles.
- Asynchronous reset mid-frame or mid-bus-cycle:
  - All outputs return to their reset values immediately.
  - The partial frame is discarded.
  - An in-flight bus cycle is abandoned with no response byte.

## Test plan
- **Write LED register:** send `'W'`, 00 00 00 02, A5 00 00 00. Required:
  - one `mem_valid` pulse with `mem_addr`=0x0200_0000, `mem_wdata`=0x0000_00A5, `mem_wstrb`=F;
  - response `'K'`;
  - `mem_valid` low the cycle after `mem_ready`.
- **Read RAM:** responder returns 0xDEADBEEF after 3 cycles for `'R'`, 04 10 00 00. Required:
  - `mem_addr`=0x0000_1004, `mem_wstrb`=0;
  - tx bytes EF BE AD DE.
- **Misaligned address and unknown command:**
  - `'R'`, 07 10 00 00 must give `mem_addr`=0x0000_1004.
  - Byte 0x41 must give `'?'` and no `mem_valid`.
- **Timeout** with `TIMEOUT`=8 and a responder that never acks: `'R'`, 00 00 00 09. Required:
  - `mem_valid` high for exactly 8 cycles;
  - response `'T'` only;
  - the next frame works normally.
- **Backpressure:** `tx_ready` toggles 0/1 on every cycle and `rx_valid` stays high during BUS. Required:
  - `tx_data` stable while stalled;
  - all 4 read bytes delivered in order;
  - `rx_ready`=0 until IDLE.
- **Reset mid-operation:** assert `resetn`=0 while `mem_valid`=1, during the 2nd write data byte. Required:
  - all outputs at reset values in the same cycle;
  - after release, a clean `'W'` frame yields `'K'`.
